data_scan_ctrl: RTL and testbench



---
 rtl/data_scan_ctrl.sv | 155 +++++++++++++++
 tb/tb_data_scan_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_scan_ctrl.sv
// -----------------------------------------------------------------------------
// data_scan_ctrl
// Steps through a window of data-memory word addresses, one step per debounced
// button press. Each step reads one word and keeps its low byte as a character
// code for the 7-segment decoder. The block only reads memory and never stalls
// the processor.
//
// Optional feature: define DATA_SCAN_AUTO_SCAN_EN to also step automatically
// every AUTO_PERIOD cycles spent in IDLE.
//
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous, active-high reset
//   btn_in     in   raw button level (asynchronous, active-high)
//   rdata      in   word returned by the display read port for addr
//   addr       out  display read address (ADDR_W bits)
//   char_code  out  latched character code (rdata[7:0])
//   char_valid out  high once a character has been latched since reset
//   busy       out  high while a fetch is in progress (REQ, WAIT, LATCH)
// -----------------------------------------------------------------------------
module data_scan_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned ADDR_W          = 8,
  parameter int unsigned START_ADDR      = 0,
  parameter int unsigned END_ADDR        = 63,
  parameter int unsigned AUTO_PERIOD     = 25000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_in,
  input  logic [31:0]       rdata,
  output logic [ADDR_W-1:0] addr,
  output logic [7:0]        char_code,
  output logic              char_valid,
  output logic              busy
);

  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [ADDR_W-1:0] START_A = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] END_A   = ADDR_W'(END_ADDR);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_LATCH = 2'd3
  } state_t;

  state_t            r_state;
  logic              r_sync1;
  logic              r_sync2;
  logic              r_stable;
  logic              r_press;
  logic [DB_W-1:0]   r_db_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_char;
  logic              r_valid;
  logic              r_busy;
  logic              w_step;

  // Only the low byte of the word is displayed.
  logic w_unused_rdata;
  assign w_unused_rdata = ^rdata[31:8];

  // Two-flop synchronizer followed by a stability counter; a press is the
  // registered 0->1 change of the accepted level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_stable <= 1'b0;
      r_press  <= 1'b0;
      r_db_cnt <= '0;
    end else begin
      r_sync1 <= btn_in;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 == r_stable) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        r_stable <= r_sync2;
        r_db_cnt <= '0;
        r_press  <= r_sync2;
      end else begin
        r_db_cnt <= r_db_cnt + DB_W'(1);
      end
    end
  end

`ifdef DATA_SCAN_AUTO_SCAN_EN
  localparam int unsigned AUTO_W = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;

  logic [AUTO_W-1:0] r_auto_cnt;
  logic              w_auto_step;

  assign w_auto_step = (r_state == S_IDLE) && (r_auto_cnt == AUTO_W'(AUTO_PERIOD - 1));

  // Counts IDLE cycles; held at zero during a fetch and restarted by any step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_auto_cnt <= '0;
    end else if ((r_state != S_IDLE) || r_press || w_auto_step) begin
      r_auto_cnt <= '0;
    end else begin
      r_auto_cnt <= r_auto_cnt + AUTO_W'(1);
    end
  end

  assign w_step = r_press | w_auto_step;
`else
  logic w_unused_auto;
  assign w_unused_auto = (AUTO_PERIOD == 0);
  assign w_step = r_press;
`endif

  // Fetch sequencer. REQ gives a registered-read memory its address cycle;
  // steps arriving outside IDLE are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_addr  <= START_A;
      r_char  <= 8'h00;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_step) begin
            r_state <= S_REQ;
            r_busy  <= 1'b1;
          end
        end
        S_REQ:  r_state <= S_WAIT;
        S_WAIT: r_state <= S_LATCH;
        S_LATCH: begin
          r_char  <= rdata[7:0];
          r_valid <= 1'b1;
          r_addr  <= (r_addr == END_A) ? START_A : r_addr + ADDR_W'(1);
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign addr       = r_addr;
  assign char_code  = r_char;
  assign char_valid = r_valid;
  assign busy       = r_busy;

endmodule

// File: tb/tb_data_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_data_scan_ctrl
// Bench for data_scan_ctrl (window 2..4). u_dut uses a 4-cycle debounce and is
// checked every cycle against a rule-level model; u_dut_fast uses a 1-cycle
// debounce so a second press can land inside a fetch.
// -----------------------------------------------------------------------------
module tb_data_scan_ctrl;

  localparam int unsigned DEB   = 4;
  localparam int unsigned START = 2;
  localparam int unsigned ENDA  = 4;

  logic        clk;
  logic        reset;
  logic        btn_in;
  logic        btn_fast;
  logic [31:0] rdata;
  logic [31:0] rdata_f;
  logic [7:0]  addr;
  logic [7:0]  addr_f;
  logic [7:0]  char_code;
  logic [7:0]  char_f;
  logic        char_valid;
  logic        valid_f;
  logic        busy;
  logic        busy_f;

  int checks   = 0;
  int failures = 0;

  data_scan_ctrl #(
    .DEBOUNCE_CYCLES(DEB), .ADDR_W(8), .START_ADDR(START), .END_ADDR(ENDA), .AUTO_PERIOD(10)
  ) u_dut (
    .clk(clk), .reset(reset), .btn_in(btn_in), .rdata(rdata),
    .addr(addr), .char_code(char_code), .char_valid(char_valid), .busy(busy)
  );

  data_scan_ctrl #(
    .DEBOUNCE_CYCLES(1), .ADDR_W(8), .START_ADDR(START), .END_ADDR(ENDA), .AUTO_PERIOD(10)
  ) u_dut_fast (
    .clk(clk), .reset(reset), .btn_in(btn_fast), .rdata(rdata_f),
    .addr(addr_f), .char_code(char_f), .char_valid(valid_f), .busy(busy_f)
  );

  // Memory returns a word tagged with its own address.
  assign rdata   = 32'hAB00_0040 + {24'h0, addr};
  assign rdata_f = 32'hAB00_0040 + {24'h0, addr_f};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Rule-level model: a press is the level seen two clocks late having differed
  // from the accepted level for DEB consecutive samples; a press seen while no
  // fetch is pending starts a 3-cycle busy window whose last cycle reads memory.
  logic       m_s1, m_s2, m_stable, m_press, m_valid;
  int         m_run, m_cd;
  logic [7:0] m_addr, m_char;

  always @(posedge clk or posedge reset) begin
    logic p_new;
    if (reset) begin
      m_s1 = 1'b0; m_s2 = 1'b0; m_stable = 1'b0; m_press = 1'b0;
      m_run = 0; m_cd = 0;
      m_addr = 8'(START); m_char = 8'h00; m_valid = 1'b0;
    end else begin
      p_new = 1'b0;
      if (m_s2 != m_stable) begin
        m_run++;
        if (m_run == int'(DEB)) begin
          m_stable = m_s2;
          m_run    = 0;
          p_new    = m_s2;
        end
      end else begin
        m_run = 0;
      end
      if (m_cd != 0) begin
        if (m_cd == 1) begin
          m_char  = 8'(32'h40 + 32'(m_addr));
          m_valid = 1'b1;
          m_addr  = (32'(m_addr) == ENDA) ? 8'(START) : m_addr + 8'd1;
        end
        m_cd--;
      end else if (m_press) begin
        m_cd = 3;
      end
      m_s2    = m_s1;
      m_s1    = btn_in;
      m_press = p_new;
    end
  end

  // Cycle-by-cycle comparison of u_dut against the model.
  always @(negedge clk) begin
    if (!reset) begin
      check("addr", 32'(addr), 32'(m_addr));
      check("char_code", 32'(char_code), 32'(m_char));
      check("char_valid", 32'(char_valid), 32'(m_valid));
      check("busy", 32'(busy), 32'(m_cd != 0));
    end
  end

  // Busy-cycle and busy-window counters for both instances.
  int   busy_cnt = 0, busy_win = 0, busy_f_cnt = 0;
  logic busy_q   = 1'b0;
  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (busy && !busy_q) busy_win++;
    busy_q = busy;
    if (busy_f) busy_f_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic press();
    btn_in = 1'b1;
    tick(10);
    btn_in = 1'b0;
    tick(12);
  endtask

  initial begin
    int         b0, w0, f0;
    bit         seen;
    logic [7:0] exp_seq [4];
    exp_seq[0] = 8'h42; exp_seq[1] = 8'h43; exp_seq[2] = 8'h44; exp_seq[3] = 8'h42;

    // Reset held for 3 cycles.
    reset = 1'b1; btn_in = 1'b0; btn_fast = 1'b0;
    tick(3);
    check("rst_addr", 32'(addr), 32'h2);
    check("rst_char", 32'(char_code), 32'h0);
    check("rst_valid", 32'(char_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    b0 = busy_cnt;
    tick(20);
    check("idle_addr", 32'(addr), 32'h2);
    check("idle_valid", 32'(char_valid), 32'h0);
    check("idle_busy_cycles", 32'(busy_cnt - b0), 32'h0);

    // Bounce rejection.
    b0 = busy_cnt;
    for (int i = 0; i < 12; i++) begin
      btn_in = (i % 2 == 0);
      tick(1);
    end
    btn_in = 1'b0;
    tick(20);
    check("bounce_busy_cycles", 32'(busy_cnt - b0), 32'h0);
    check("bounce_addr", 32'(addr), 32'h2);
    check("bounce_valid", 32'(char_valid), 32'h0);

    // Single held press gives exactly one 3-cycle fetch.
    b0 = busy_cnt; w0 = busy_win;
    btn_in = 1'b1;
    tick(10);
    btn_in = 1'b0;
    tick(20);
    check("press_busy_cycles", 32'(busy_cnt - b0), 32'h3);
    check("press_busy_windows", 32'(busy_win - w0), 32'h1);
    check("press_char", 32'(char_code), 32'h42);
    check("press_valid", 32'(char_valid), 32'h1);
    check("press_addr", 32'(addr), 32'h3);
    check("model_char", 32'(m_char), 32'h42);

    // Wrap across the window.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      press();
      check($sformatf("wrap_char%0d", i), 32'(char_code), 32'(exp_seq[i]));
    end
    check("wrap_addr", 32'(addr), 32'h3);

    // Reset asserted while the fetch is in WAIT.
    btn_in = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
    end
    check("midfetch_busy_seen", 32'(seen), 32'h1);
    @(posedge clk);
    #2;
    reset  = 1'b1;
    btn_in = 1'b0;
    #1;
    check("midfetch_char", 32'(char_code), 32'h0);
    check("midfetch_valid", 32'(char_valid), 32'h0);
    check("midfetch_addr", 32'(addr), 32'h2);
    check("midfetch_busy", 32'(busy), 32'h0);
    tick(2);
    reset = 1'b0;
    tick(20);
    check("post_reset_valid", 32'(char_valid), 32'h0);
    check("post_reset_addr", 32'(addr), 32'h2);

    // Second press landing during the fetch is dropped (1-cycle debounce).
    f0 = busy_f_cnt;
    btn_fast = 1'b1; tick(1);
    btn_fast = 1'b0; tick(1);
    btn_fast = 1'b1; tick(1);
    btn_fast = 1'b0;
    tick(20);
    check("drop_busy_cycles", 32'(busy_f_cnt - f0), 32'h3);
    check("drop_addr", 32'(addr_f), 32'h3);
    check("drop_char", 32'(char_f), 32'h42);
    check("drop_valid", 32'(valid_f), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
